bpred_resolve_queue: RTL and testbench
======================================

Name: bpred_resolve_queue

Overview:
- In-order tracking queue downstream of the perceptron branch predictor.
- Each branch prediction made at fetch is enqueued with its metadata: PC, predicted direction, predicted target, perceptron sum, call/return flags.
- When execute resolves the oldest branch, the block pops the head, compares prediction against outcome, and drives the predictor's update/training interface, the fetch redirect and RAS-repair qualifiers.
- On a mispredict, all younger (wrong-path) entries are flushed.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 2.
- SUM_W, 7, width of signed perceptron sum stored per entry.
- THETA, 4, training threshold; train when |sum| <= THETA.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enq_valid  in  1  fetch has a predicted branch this cycle
- enq_ready  out  1  queue can accept; equals ~full
- enq_pc  in  32  branch PC
- enq_pred_dir  in  1  predicted taken
- enq_pred_target  in  32  predicted target (don't-care if not taken)
- enq_sum  in  SUM_W  signed perceptron sum at prediction
- enq_is_call  in  1  branch is a call
- enq_is_ret  in  1  branch is a return
- stall  in  1  pipeline stall; freezes resolution
- res_valid  in  1  execute resolved oldest branch
- res_dir  in  1  actual direction
- res_target  in  32  actual taken target
- upd_valid  out  1  predictor update strobe
- upd_pc4  out  32  resolved PC+4
- upd_target  out  32  actual target
- upd_dir  out  1  actual direction
- upd_miss  out  1  mispredicted
- upd_train  out  1  perceptron weights must be trained
- redirect_valid  out  1  fetch must restart
- redirect_pc  out  32  restart PC
- c_r_after_r  out  1  mispredicted call/return resolved right after a return
- upd_is_call  out  1  resolved branch was a call
- occupancy  out  log2(DEPTH)+1  valid entries
- err_underflow  out  1  sticky: res_valid seen with empty queue
- resolved_count  out  32  branches resolved
- miss_count  out  32  mispredicts

Behaviour:
- All outputs registered. Reset values:
  - Every output 0, except enq_ready = 1.
  - Pointers 0, last_was_ret = 0.
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a separate count; full when count == DEPTH.
- Enqueue: enq_valid & enq_ready writes at tail, tail++. enq_valid while full is dropped; no state change.
- Resolve: when res_valid & ~stall & count > 0, pop head. Results appear on outputs the next cycle (1-cycle latency).
- Miss rule: miss = (res_dir != pred_dir) | (res_dir & pred_dir & (res_target != pred_target)).
- Update outputs:
  - upd_valid = 1 for exactly one cycle per pop.
  - upd_pc4 = pc + 4 (mod 2^32).
  - upd_target = res_target; upd_dir = res_dir; upd_miss = miss.
- Training: upd_train = miss | (|sum| <= THETA).
  - |sum| is computed in SUM_W+1 bits, so the most negative value (-64 for SUM_W=7) gives magnitude 64, no overflow.
- Redirect: redirect_valid = miss. redirect_pc = res_dir ? res_target : pc + 4.
- Flush: on a miss pop, all remaining entries are discarded in the same cycle: count -> 0, tail := head+1.
  - An enqueue in that same cycle is dropped (wrong path).
- Simultaneous enqueue and non-miss pop: both take effect; count unchanged. Allowed even when full only if the pop happens; enq_ready still reflects the registered ~full.
- RAS qualifiers:
  - last_was_ret updates on every pop to the popped entry's is_ret.
  - c_r_after_r = miss & (is_call | is_ret) & last_was_ret, using the pre-pop value of last_was_ret.
  - upd_is_call = popped is_call.
- Stall: res_valid is ignored while stall = 1. Execute holds res_* until stall drops. Enqueue is not affected by stall.
- Underflow: res_valid & ~stall & count == 0 sets err_underflow, which stays set until reset. No outputs strobe.
- Counters:
  - resolved_count increments per pop; miss_count increments per miss pop.
  - Both wrap at 2^32.
- Reset mid-operation: queue is emptied and counters cleared; res_valid/enq_valid in the reset cycle are ignored.

Test Plan:
- Correct taken branch: enqueue pc=0x40, pred_dir=1, target=0x80, sum=+20; resolve dir=1, target=0x80 -> next cycle upd_valid=1, upd_pc4=0x44, upd_miss=0, upd_train=0, redirect_valid=0.
- Direction miss with flush: enqueue three branches (pc 0x10, 0x20, 0x30); resolve head pred=1, actual=0 -> redirect_pc=0x14, upd_miss=1, upd_train=1, occupancy=0, miss_count=1; an enqueue in the same cycle is dropped.
- Target miss plus threshold training:
  - pred_dir=1, target 0x100, actual target 0x104 -> miss=1, redirect_pc=0x104.
  - Separately, a correct prediction with sum=-4 -> upd_train=1; with sum=-64 -> upd_train=0, and |sum| is evaluated as 64 with no overflow.
- Full/wrap: enqueue 8 entries -> enq_ready=0; 9th is dropped; concurrent correct pop + enqueue keeps occupancy=8; 20 enqueue/pop pairs wrap pointers with FIFO order preserved.
- Stall and underflow: res_valid held under stall for 3 cycles -> no upd_valid; stall drops -> exactly one pop. res_valid on an empty queue -> err_underflow=1, sticky until reset.
- RAS: pop a correctly predicted return, then a call mispredicted -> c_r_after_r=1, upd_is_call=1; the same call after a non-return -> c_r_after_r=0.

Source files
------------

// File: rtl/bpred_resolve_queue.sv
// In-order branch resolve queue: tracks fetch-time predictions, compares them
// against execute outcomes, and drives predictor training, redirect and RAS-repair strobes.
module bpred_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int SUM_W = 7,
  parameter int THETA = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_pc,
  input  logic                     enq_pred_dir,
  input  logic [31:0]              enq_pred_target,
  input  logic signed [SUM_W-1:0]  enq_sum,
  input  logic                     enq_is_call,
  input  logic                     enq_is_ret,
  input  logic                     stall,
  input  logic                     res_valid,
  input  logic                     res_dir,
  input  logic [31:0]              res_target,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc4,
  output logic [31:0]              upd_target,
  output logic                     upd_dir,
  output logic                     upd_miss,
  output logic                     upd_train,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     c_r_after_r,
  output logic                     upd_is_call,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_underflow,
  output logic [31:0]              resolved_count,
  output logic [31:0]              miss_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SUM_W:0] L_THETA = (SUM_W+1)'(THETA);

  logic [31:0]       r_pc_mem  [DEPTH];
  logic              r_dir_mem [DEPTH];
  logic [31:0]       r_tgt_mem [DEPTH];
  logic [SUM_W-1:0]  r_sum_mem [DEPTH];
  logic              r_call_mem[DEPTH];
  logic              r_ret_mem [DEPTH];

  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_last_was_ret;

  logic              w_full;
  logic              w_pop;
  logic              w_miss;
  logic              w_flush;
  logic              w_enq;
  logic              w_train;
  logic [31:0]       w_pc4;
  logic [SUM_W:0]    w_sum_ext;
  logic [SUM_W:0]    w_abs;
  logic [CW-1:0]     w_count_nxt;

  assign occupancy = r_count;

  // Head evaluation, |sum| in SUM_W+1 bits so the most negative sum cannot overflow
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_pop     = res_valid & ~stall & (r_count != {CW{1'b0}});
    w_miss    = (res_dir != r_dir_mem[r_head]) |
                (res_dir & r_dir_mem[r_head] & (res_target != r_tgt_mem[r_head]));
    w_pc4     = r_pc_mem[r_head] + 32'd4;
    w_sum_ext = {r_sum_mem[r_head][SUM_W-1], r_sum_mem[r_head]};
    if (w_sum_ext[SUM_W]) begin
      w_abs = -w_sum_ext;
    end else begin
      w_abs = w_sum_ext;
    end
    w_train   = w_miss | (w_abs <= L_THETA);
    w_flush   = w_pop & w_miss;
    // A pop frees a slot this cycle, so a full queue can still take a same-cycle enqueue
    w_enq     = enq_valid & ~w_flush & (~w_full | w_pop);
    if (w_flush) begin
      w_count_nxt = {CW{1'b0}};
    end else if (w_enq & ~w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (~w_enq & w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Entry storage write at tail
  always_ff @(posedge clk) begin
    if (w_enq & ~reset) begin
      r_pc_mem[r_tail]   <= enq_pc;
      r_dir_mem[r_tail]  <= enq_pred_dir;
      r_tgt_mem[r_tail]  <= enq_pred_target;
      r_sum_mem[r_tail]  <= enq_sum;
      r_call_mem[r_tail] <= enq_is_call;
      r_ret_mem[r_tail]  <= enq_is_ret;
    end
  end

  // Pointers, counters and registered resolve outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head         <= {AW{1'b0}};
      r_tail         <= {AW{1'b0}};
      r_count        <= {CW{1'b0}};
      r_last_was_ret <= 1'b0;
      enq_ready      <= 1'b1;
      upd_valid      <= 1'b0;
      upd_pc4        <= 32'd0;
      upd_target     <= 32'd0;
      upd_dir        <= 1'b0;
      upd_miss       <= 1'b0;
      upd_train      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      c_r_after_r    <= 1'b0;
      upd_is_call    <= 1'b0;
      err_underflow  <= 1'b0;
      resolved_count <= 32'd0;
      miss_count     <= 32'd0;
    end else begin
      r_count        <= w_count_nxt;
      enq_ready      <= (w_count_nxt != CW'(DEPTH));
      upd_valid      <= w_pop;
      redirect_valid <= w_flush;
      c_r_after_r    <= w_flush & (r_call_mem[r_head] | r_ret_mem[r_head]) & r_last_was_ret;
      // Mispredict drops every younger entry: queue restarts just past the popped head
      if (w_flush) begin
        r_head <= r_head + AW'(1);
        r_tail <= r_head + AW'(1);
      end else begin
        if (w_pop) r_head <= r_head + AW'(1);
        if (w_enq) r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        upd_pc4        <= w_pc4;
        upd_target     <= res_target;
        upd_dir        <= res_dir;
        upd_miss       <= w_miss;
        upd_train      <= w_train;
        redirect_pc    <= res_dir ? res_target : w_pc4;
        upd_is_call    <= r_call_mem[r_head];
        r_last_was_ret <= r_ret_mem[r_head];
        resolved_count <= resolved_count + 32'd1;
        if (w_miss) miss_count <= miss_count + 32'd1;
      end
      if (res_valid & ~stall & (r_count == {CW{1'b0}})) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Directed bench for bpred_resolve_queue with a behavioural queue model and
// a scoreboard of expected resolve results compared one cycle after each pop.
module tb_bpred_resolve_queue;

  logic               clk = 1'b0;
  logic               reset;
  logic               enq_valid;
  logic               enq_ready;
  logic [31:0]        enq_pc;
  logic               enq_pred_dir;
  logic [31:0]        enq_pred_target;
  logic signed [6:0]  enq_sum;
  logic               enq_is_call;
  logic               enq_is_ret;
  logic               stall;
  logic               res_valid;
  logic               res_dir;
  logic [31:0]        res_target;
  logic               upd_valid;
  logic [31:0]        upd_pc4;
  logic [31:0]        upd_target;
  logic               upd_dir;
  logic               upd_miss;
  logic               upd_train;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               c_r_after_r;
  logic               upd_is_call;
  logic [3:0]         occupancy;
  logic               err_underflow;
  logic [31:0]        resolved_count;
  logic [31:0]        miss_count;

  bpred_resolve_queue #(.DEPTH(8), .SUM_W(7), .THETA(4)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred_dir(enq_pred_dir), .enq_pred_target(enq_pred_target), .enq_sum(enq_sum),
    .enq_is_call(enq_is_call), .enq_is_ret(enq_is_ret),
    .stall(stall), .res_valid(res_valid), .res_dir(res_dir), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc4(upd_pc4), .upd_target(upd_target), .upd_dir(upd_dir),
    .upd_miss(upd_miss), .upd_train(upd_train),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .c_r_after_r(c_r_after_r), .upd_is_call(upd_is_call),
    .occupancy(occupancy), .err_underflow(err_underflow),
    .resolved_count(resolved_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic              dir;
    logic [31:0]       tgt;
    logic signed [6:0] sum;
    logic              call;
    logic              ret;
  } ent_t;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        dir;
    logic        miss;
    logic        train;
    logic [31:0] rpc;
    logic        crr;
    logic        call;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  logic        m_last_ret;
  logic        m_err;
  logic [31:0] m_res;
  logic [31:0] m_miss;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [31:0] pc, input logic dir, input logic [31:0] tgt,
                     input logic [6:0] sum, input logic call, input logic ret);
    enq_valid = 1'b1; enq_pc = pc; enq_pred_dir = dir; enq_pred_target = tgt;
    enq_sum = sum; enq_is_call = call; enq_is_ret = ret;
  endtask

  task automatic res(input logic dir, input logic [31:0] tgt);
    res_valid = 1'b1; res_dir = dir; res_target = tgt;
  endtask

  // One clock: update the model from the driven inputs, then check the DUT after the edge
  task automatic tick();
    ent_t h;
    exp_t e;
    bit pop;
    bit miss;
    int sz;
    int s;
    miss = 1'b0;
    pop = 1'b0;
    if (reset) begin
      mq.delete(); sb.delete();
      m_last_ret = 1'b0; m_err = 1'b0; m_res = 32'd0; m_miss = 32'd0;
    end else begin
      sz = mq.size();
      pop = res_valid && !stall && sz > 0;
      if (res_valid && !stall && sz == 0) m_err = 1'b1;
      if (pop) begin
        h = mq.pop_front();
        miss = (res_dir != h.dir) || (res_dir && h.dir && (res_target != h.tgt));
        s = int'(h.sum);
        e.pc4   = h.pc + 32'd4;
        e.tgt   = res_target;
        e.dir   = res_dir;
        e.miss  = miss;
        e.train = miss || ((s < 0 ? -s : s) <= 4);
        e.rpc   = res_dir ? res_target : h.pc + 32'd4;
        e.crr   = miss && (h.call || h.ret) && m_last_ret;
        e.call  = h.call;
        sb.push_back(e);
        m_last_ret = h.ret;
        m_res = m_res + 32'd1;
        if (miss) begin
          m_miss = m_miss + 32'd1;
          mq.delete();
        end
      end
      if (enq_valid && !(pop && miss) && (sz < 8 || pop)) begin
        h.pc = enq_pc; h.dir = enq_pred_dir; h.tgt = enq_pred_target;
        h.sum = enq_sum; h.call = enq_is_call; h.ret = enq_is_ret;
        mq.push_back(h);
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("upd_valid", 32'(upd_valid), 32'd1);
      check("upd_pc4", upd_pc4, e.pc4);
      check("upd_target", upd_target, e.tgt);
      check("upd_dir", 32'(upd_dir), 32'(e.dir));
      check("upd_miss", 32'(upd_miss), 32'(e.miss));
      check("upd_train", 32'(upd_train), 32'(e.train));
      check("redirect_valid", 32'(redirect_valid), 32'(e.miss));
      if (e.miss) check("redirect_pc", redirect_pc, e.rpc);
      check("c_r_after_r", 32'(c_r_after_r), 32'(e.crr));
      check("upd_is_call", 32'(upd_is_call), 32'(e.call));
    end else begin
      check("upd_valid_idle", 32'(upd_valid), 32'd0);
      check("redirect_valid_idle", 32'(redirect_valid), 32'd0);
    end
    check("occupancy", 32'(occupancy), 32'(mq.size()));
    check("enq_ready", 32'(enq_ready), 32'(mq.size() != 8));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
    check("resolved_count", resolved_count, m_res);
    check("miss_count", miss_count, m_miss);
    enq_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    ent_t hd;
    reset = 1'b1; enq_valid = 1'b0; enq_pc = 32'd0; enq_pred_dir = 1'b0;
    enq_pred_target = 32'd0; enq_sum = 7'd0; enq_is_call = 1'b0; enq_is_ret = 1'b0;
    stall = 1'b0; res_valid = 1'b0; res_dir = 1'b0; res_target = 32'd0;
    tick(); tick();
    check("reset_enq_ready", 32'(enq_ready), 32'd1);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    reset = 1'b0;

    // Correct taken branch
    enq(32'h40, 1'b1, 32'h80, 7'd20, 1'b0, 1'b0); tick();
    res(1'b1, 32'h80); tick();
    check("t1_pc4", upd_pc4, 32'h44);
    check("t1_miss", 32'(upd_miss), 32'd0);
    check("t1_train", 32'(upd_train), 32'd0);
    check("t1_redirect", 32'(redirect_valid), 32'd0);

    // Direction miss flushes younger entries and drops same-cycle enqueue
    enq(32'h10, 1'b1, 32'h50, 7'd30, 1'b0, 1'b0); tick();
    enq(32'h20, 1'b0, 32'h0, 7'd30, 1'b0, 1'b0); tick();
    enq(32'h30, 1'b0, 32'h0, 7'd30, 1'b0, 1'b0); tick();
    res(1'b0, 32'h0); enq(32'h90, 1'b0, 32'h0, 7'd30, 1'b0, 1'b0); tick();
    check("t2_redirect_pc", redirect_pc, 32'h14);
    check("t2_miss", 32'(upd_miss), 32'd1);
    check("t2_train", 32'(upd_train), 32'd1);
    check("t2_occupancy", 32'(occupancy), 32'd0);
    check("t2_miss_count", miss_count, 32'd1);

    // Target miss, then threshold training at sum=-4 and sum=-64
    enq(32'h200, 1'b1, 32'h100, 7'd30, 1'b0, 1'b0); tick();
    res(1'b1, 32'h104); tick();
    check("t3_miss", 32'(upd_miss), 32'd1);
    check("t3_redirect_pc", redirect_pc, 32'h104);
    enq(32'h300, 1'b0, 32'h0, 7'h7C, 1'b0, 1'b0); tick();
    res(1'b0, 32'h0); tick();
    check("t3_train_m4", 32'(upd_train), 32'd1);
    enq(32'h304, 1'b0, 32'h0, 7'h40, 1'b0, 1'b0); tick();
    res(1'b0, 32'h0); tick();
    check("t3_train_m64", 32'(upd_train), 32'd0);

    // Fill, overflow drop, concurrent pop+enqueue, then wrap with FIFO order
    for (int i = 0; i < 8; i++) begin
      enq(32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i), 7'd10, 1'b0, 1'b0); tick();
    end
    check("t4_full_ready", 32'(enq_ready), 32'd0);
    enq(32'h1F00, 1'b0, 32'h0, 7'd10, 1'b0, 1'b0); tick();
    check("t4_drop_occ", 32'(occupancy), 32'd8);
    hd = mq[0]; res(hd.dir, hd.tgt); enq(32'h1F04, 1'b1, 32'h1F80, 7'd10, 1'b0, 1'b0); tick();
    check("t4_concurrent_occ", 32'(occupancy), 32'd8);
    for (int i = 0; i < 20; i++) begin
      hd = mq[0]; res(hd.dir, hd.tgt);
      enq(32'h3000 + 32'(i * 8), i[1], 32'h4000 + 32'(i), 7'd9, 1'b0, 1'b0); tick();
    end
    check("t4_wrap_occ", 32'(occupancy), 32'd8);
    for (int i = 0; i < 8; i++) begin
      hd = mq[0]; res(hd.dir, hd.tgt); tick();
    end
    check("t4_drain_occ", 32'(occupancy), 32'd0);

    // Stall holds resolution, then exactly one pop
    enq(32'h700, 1'b0, 32'h0, 7'd10, 1'b0, 1'b0); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res(1'b0, 32'h0); tick();
    end
    stall = 1'b0; res(1'b0, 32'h0); tick();
    check("t5_stall_pop_pc4", upd_pc4, 32'h704);
    tick();

    // Underflow is sticky
    res(1'b0, 32'h0); tick();
    check("t5_underflow", 32'(err_underflow), 32'd1);
    tick(); tick();
    check("t5_underflow_sticky", 32'(err_underflow), 32'd1);

    // RAS: correct return, then mispredicted call
    enq(32'h500, 1'b1, 32'h600, 7'd20, 1'b0, 1'b1); tick();
    enq(32'h504, 1'b0, 32'h0, 7'd20, 1'b1, 1'b0); tick();
    res(1'b1, 32'h600); tick();
    res(1'b1, 32'h700); tick();
    check("t6_crr", 32'(c_r_after_r), 32'd1);
    check("t6_is_call", 32'(upd_is_call), 32'd1);
    enq(32'h800, 1'b0, 32'h0, 7'd20, 1'b0, 1'b0); tick();
    enq(32'h804, 1'b0, 32'h0, 7'd20, 1'b1, 1'b0); tick();
    res(1'b0, 32'h0); tick();
    res(1'b1, 32'h700); tick();
    check("t6_crr_nonret", 32'(c_r_after_r), 32'd0);

    // Reset mid-operation ignores same-cycle enqueue and resolve
    enq(32'hA00, 1'b0, 32'h0, 7'd20, 1'b0, 1'b0); tick();
    enq(32'hA04, 1'b0, 32'h0, 7'd20, 1'b0, 1'b0); tick();
    reset = 1'b1; enq(32'hA08, 1'b0, 32'h0, 7'd20, 1'b0, 1'b0); res(1'b0, 32'h0); tick();
    reset = 1'b0;
    check("t7_occ", 32'(occupancy), 32'd0);
    check("t7_resolved", resolved_count, 32'd0);
    check("t7_err", 32'(err_underflow), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
